mem_wb_stage: RTL and testbench

//   MEM->WB pipeline stage of the MIPS32 core; drives the register file write port.
//   - Selects the ALU result or the load data from data memory.
//   - Aligns and sign/zero-extends loads: LB/LBU/LH/LHU/LW, plus LWL/LWR merge. Byte order is big-endian.
//   - Waits on the data-memory acknowledge and stalls the upstream pipeline while a load is pending.
//   - Optional timeout aborts a hung load and raises BusError.
//

---
 rtl/mem_wb_stage.sv | 136 +++++++++++++
 tb/tb_mem_wb_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register for the MIPS32 core: load alignment/extension, data-memory
// ack wait with optional timeout, and the register file write port.
module mem_wb_stage #(
   parameter int unsigned ACK_TIMEOUT = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        M_Valid,
   input  logic        M_Flush,
   input  logic        M_RegWrite,
   input  logic        M_MemRead,
   input  logic [2:0]  M_LoadType,
   input  logic [1:0]  M_AddrLo,
   input  logic [4:0]  M_WriteReg,
   input  logic [31:0] M_ALUResult,
   input  logic [31:0] M_RtData,
   input  logic [31:0] Mem_DataIn,
   input  logic        Mem_Ack,
   output logic        M_Stall,
   output logic        BusError,
   output logic        WB_RegWrite,
   output logic [4:0]  WB_WriteReg,
   output logic [31:0] WB_WriteData
);

   localparam logic       TimeoutEn  = (ACK_TIMEOUT != 0);
   localparam logic [7:0] TimeoutLim = 8'(ACK_TIMEOUT);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e      state, stateNext;
   logic [7:0]  waitCnt, waitCntNext;
   logic        ld, tmo, bubble;
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadData;

   assign ld  = M_Valid & M_MemRead & ~M_Flush;
   assign tmo = (state == StWait) & TimeoutEn & (waitCnt == TimeoutLim) & ~Mem_Ack;

   // Both flags are forced low while reset is asserted.
   assign M_Stall  = ~reset & ld & ~Mem_Ack & ~tmo;
   assign BusError = ~reset & tmo;

   assign bubble = ~M_Valid | M_Flush | M_Stall | tmo;

   always_comb begin
      stateNext   = state;
      waitCntNext = waitCnt;
      unique case (state)
         StIdle: begin
            if (ld && !Mem_Ack) begin
               stateNext   = StWait;
               waitCntNext = 8'd1;
            end
         end
         StWait: begin
            if (M_Flush || Mem_Ack || tmo) begin
               stateNext   = StIdle;
               waitCntNext = 8'd0;
            end else if (waitCnt != 8'hFF) begin
               waitCntNext = waitCnt + 8'd1;
            end
         end
         default: begin
            stateNext   = StIdle;
            waitCntNext = 8'd0;
         end
      endcase
   end

   // Big-endian lane select: address 0 is the most significant byte.
   always_comb begin
      loadByte = 8'h00;
      unique case (M_AddrLo)
         2'd0: loadByte = Mem_DataIn[31:24];
         2'd1: loadByte = Mem_DataIn[23:16];
         2'd2: loadByte = Mem_DataIn[15:8];
         2'd3: loadByte = Mem_DataIn[7:0];
         default: loadByte = 8'h00;
      endcase
   end

   assign loadHalf = M_AddrLo[1] ? Mem_DataIn[15:0] : Mem_DataIn[31:16];

   always_comb begin
      loadData = Mem_DataIn;
      case (M_LoadType)
         3'd1: loadData = {{24{loadByte[7]}}, loadByte};
         3'd2: loadData = {24'h000000, loadByte};
         3'd3: loadData = {{16{loadHalf[15]}}, loadHalf};
         3'd4: loadData = {16'h0000, loadHalf};
         3'd5: begin
            unique case (M_AddrLo)
               2'd0: loadData = Mem_DataIn;
               2'd1: loadData = {Mem_DataIn[23:0], M_RtData[7:0]};
               2'd2: loadData = {Mem_DataIn[15:0], M_RtData[15:0]};
               2'd3: loadData = {Mem_DataIn[7:0], M_RtData[23:0]};
               default: loadData = Mem_DataIn;
            endcase
         end
         3'd6: begin
            unique case (M_AddrLo)
               2'd0: loadData = {M_RtData[31:8], Mem_DataIn[31:24]};
               2'd1: loadData = {M_RtData[31:16], Mem_DataIn[31:16]};
               2'd2: loadData = {M_RtData[31:24], Mem_DataIn[31:8]};
               2'd3: loadData = Mem_DataIn;
               default: loadData = Mem_DataIn;
            endcase
         end
         default: loadData = Mem_DataIn;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= StIdle;
         waitCnt      <= 8'd0;
         WB_RegWrite  <= 1'b0;
         WB_WriteReg  <= 5'd0;
         WB_WriteData <= 32'd0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
         if (bubble) begin
            WB_RegWrite <= 1'b0;
            WB_WriteReg <= 5'd0;
         end else begin
            WB_RegWrite  <= M_RegWrite & (M_WriteReg != 5'd0);
            WB_WriteReg  <= M_WriteReg;
            WB_WriteData <= M_MemRead ? loadData : M_ALUResult;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (ACK_TIMEOUT=4): ALU writeback, load alignment,
// ack wait, timeout, flush and reset behaviour.
module tb_mem_wb_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        M_Valid, M_Flush, M_RegWrite, M_MemRead;
   logic [2:0]  M_LoadType;
   logic [1:0]  M_AddrLo;
   logic [4:0]  M_WriteReg;
   logic [31:0] M_ALUResult, M_RtData, Mem_DataIn;
   logic        Mem_Ack;
   logic        M_Stall, BusError, WB_RegWrite;
   logic [4:0]  WB_WriteReg;
   logic [31:0] WB_WriteData;

   int checks   = 0;
   int failures = 0;

   mem_wb_stage #(.ACK_TIMEOUT(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .M_Valid      (M_Valid),
      .M_Flush      (M_Flush),
      .M_RegWrite   (M_RegWrite),
      .M_MemRead    (M_MemRead),
      .M_LoadType   (M_LoadType),
      .M_AddrLo     (M_AddrLo),
      .M_WriteReg   (M_WriteReg),
      .M_ALUResult  (M_ALUResult),
      .M_RtData     (M_RtData),
      .Mem_DataIn   (Mem_DataIn),
      .Mem_Ack      (Mem_Ack),
      .M_Stall      (M_Stall),
      .BusError     (BusError),
      .WB_RegWrite  (WB_RegWrite),
      .WB_WriteReg  (WB_WriteReg),
      .WB_WriteData (WB_WriteData)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; sampling happens 1 time unit later.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic setIdle();
      M_Valid = 0; M_Flush = 0; M_RegWrite = 0; M_MemRead = 0; M_LoadType = 0;
      M_AddrLo = 0; M_WriteReg = 0; M_ALUResult = 0; M_RtData = 0; Mem_DataIn = 0;
      Mem_Ack = 0;
   endtask

   task automatic setAlu(input logic [4:0] wr, input logic [31:0] res);
      setIdle();
      M_Valid = 1; M_RegWrite = 1; M_WriteReg = wr; M_ALUResult = res;
   endtask

   task automatic setLoad(input logic [2:0] lt, input logic [1:0] a, input logic [4:0] wr,
                          input logic [31:0] d, input logic [31:0] rt, input logic ack);
      setIdle();
      M_Valid = 1; M_RegWrite = 1; M_MemRead = 1; M_LoadType = lt; M_AddrLo = a;
      M_WriteReg = wr; Mem_DataIn = d; M_RtData = rt; Mem_Ack = ack;
      M_ALUResult = 32'h0BAD0BAD;
   endtask

   // One-cycle load with the ack present: no stall, then the aligned value in WB.
   task automatic loadNow(input string tag, input logic [2:0] lt, input logic [1:0] a,
                          input logic [31:0] d, input logic [31:0] rt, input logic [31:0] exp);
      setLoad(lt, a, 5'd7, d, rt, 1'b1);
      #1;
      chk({tag, "_stall"}, 32'(M_Stall), 32'd0);
      cyc();
      chk({tag, "_data"}, WB_WriteData, exp);
   endtask

   initial begin
      setIdle();
      reset = 1;
      // A pending load during reset must not stall.
      setLoad(3'd0, 2'd0, 5'd3, 32'h0, 32'h0, 1'b0);
      #1;
      chk("rst_stall", 32'(M_Stall), 32'd0);
      chk("rst_buserr", 32'(BusError), 32'd0);
      cyc();
      cyc();
      chk("rst_regwrite", 32'(WB_RegWrite), 32'd0);
      chk("rst_writereg", 32'(WB_WriteReg), 32'd0);
      chk("rst_writedata", WB_WriteData, 32'd0);
      setIdle();
      reset = 0;
      cyc();

      // ALU writeback
      setAlu(5'd5, 32'h1234);
      #1;
      chk("alu_stall", 32'(M_Stall), 32'd0);
      cyc();
      chk("alu_regwrite", 32'(WB_RegWrite), 32'd1);
      chk("alu_writereg", 32'(WB_WriteReg), 32'd5);
      chk("alu_writedata", WB_WriteData, 32'h00001234);

      setAlu(5'd0, 32'h55);
      cyc();
      chk("r0_regwrite", 32'(WB_RegWrite), 32'd0);
      chk("r0_writedata", WB_WriteData, 32'h00000055);

      setIdle();
      cyc();
      chk("invalid_regwrite", 32'(WB_RegWrite), 32'd0);
      chk("invalid_hold", WB_WriteData, 32'h00000055);

      // Load alignment
      loadNow("lb_a3", 3'd1, 2'd3, 32'h123456F0, 32'h0, 32'hFFFFFFF0);
      chk("lb_regwrite", 32'(WB_RegWrite), 32'd1);
      chk("lb_writereg", 32'(WB_WriteReg), 32'd7);
      loadNow("lb_a0", 3'd1, 2'd0, 32'h80123456, 32'h0, 32'hFFFFFF80);
      loadNow("lbu_a1", 3'd2, 2'd1, 32'h12F45678, 32'h0, 32'h000000F4);
      loadNow("lh_a2", 3'd3, 2'd2, 32'h8000ABCD, 32'h0, 32'hFFFFABCD);
      loadNow("lhu_a2", 3'd4, 2'd2, 32'h8000ABCD, 32'h0, 32'h0000ABCD);
      loadNow("lh_a0", 3'd3, 2'd0, 32'h7FFFABCD, 32'h0, 32'h00007FFF);
      loadNow("lw_a2", 3'd0, 2'd2, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
      loadNow("lt7", 3'd7, 2'd1, 32'hFEEDFACE, 32'h0, 32'hFEEDFACE);
      loadNow("lwl_a1", 3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'hBBCCDD44);
      loadNow("lwr_a1", 3'd6, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h1122AABB);
      loadNow("lwl_a3", 3'd5, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'hDD223344);
      loadNow("lwr_a0", 3'd6, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h112233AA);

      // Ack delayed three cycles
      setLoad(3'd0, 2'd0, 5'd9, 32'hCAFEF00D, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("dly_stall%0d", i), 32'(M_Stall), 32'd1);
         cyc();
         chk($sformatf("dly_bubble%0d", i), 32'(WB_RegWrite), 32'd0);
      end
      Mem_Ack = 1;
      #1;
      chk("dly_ack_stall", 32'(M_Stall), 32'd0);
      cyc();
      chk("dly_regwrite", 32'(WB_RegWrite), 32'd1);
      chk("dly_writereg", 32'(WB_WriteReg), 32'd9);
      chk("dly_writedata", WB_WriteData, 32'hCAFEF00D);
      setIdle();
      cyc();

      // Timeout: four stall cycles then a one-cycle BusError
      setLoad(3'd0, 2'd0, 5'd10, 32'h11111111, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("tmo_stall%0d", i), 32'(M_Stall), 32'd1);
         chk($sformatf("tmo_noerr%0d", i), 32'(BusError), 32'd0);
         cyc();
      end
      #1;
      chk("tmo_stall_end", 32'(M_Stall), 32'd0);
      chk("tmo_buserr", 32'(BusError), 32'd1);
      cyc();
      chk("tmo_regwrite", 32'(WB_RegWrite), 32'd0);
      setIdle();
      #1;
      chk("tmo_pulse_end", 32'(BusError), 32'd0);
      cyc();

      // Flush mid-wait, then a fresh load must see the full timeout window
      setLoad(3'd0, 2'd0, 5'd11, 32'h22222222, 32'h0, 1'b0);
      cyc();
      cyc();
      cyc();
      M_Flush = 1;
      #1;
      chk("flush_stall", 32'(M_Stall), 32'd0);
      cyc();
      chk("flush_bubble", 32'(WB_RegWrite), 32'd0);
      setLoad(3'd0, 2'd0, 5'd12, 32'h33333333, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("postflush_stall%0d", i), 32'(M_Stall), 32'd1);
         cyc();
      end
      #1;
      chk("postflush_buserr", 32'(BusError), 32'd1);
      cyc();
      setIdle();
      cyc();

      // Flush together with ack: flush wins
      setLoad(3'd0, 2'd0, 5'd13, 32'h44444444, 32'h0, 1'b0);
      cyc();
      M_Flush = 1;
      Mem_Ack = 1;
      cyc();
      chk("flushack_regwrite", 32'(WB_RegWrite), 32'd0);
      chk("flushack_writereg", 32'(WB_WriteReg), 32'd0);

      // Reset during a wait clears every output
      setAlu(5'd14, 32'h5A5A5A5A);
      cyc();
      setLoad(3'd0, 2'd0, 5'd15, 32'h66666666, 32'h0, 1'b0);
      cyc();
      cyc();
      reset = 1;
      #1;
      chk("midrst_stall", 32'(M_Stall), 32'd0);
      chk("midrst_buserr", 32'(BusError), 32'd0);
      cyc();
      chk("midrst_regwrite", 32'(WB_RegWrite), 32'd0);
      chk("midrst_writereg", 32'(WB_WriteReg), 32'd0);
      chk("midrst_writedata", WB_WriteData, 32'd0);
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("postrst_stall%0d", i), 32'(M_Stall), 32'd1);
         cyc();
      end
      #1;
      chk("postrst_buserr", 32'(BusError), 32'd1);
      cyc();
      setIdle();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
